// File: rtl/jk_ff_checker_if.sv
// JK flip-flop checker signal bundle.
// master drives stimulus/observations, slave is the checker.
interface jk_ff_checker_if #(
    parameter int CNT_W = 8
);
    logic             chk_en;
    logic             dut_rst;
    logic [1:0]       state;
    logic             q;
    logic             qn;
    logic             exp_q;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] cmp_cnt;
    logic             busy;
    logic             halted;

    modport master (
        output chk_en, dut_rst, state, q, qn,
        input  exp_q, mismatch, err_cnt, cmp_cnt, busy, halted
    );

    modport slave (
        input  chk_en, dut_rst, state, q, qn,
        output exp_q, mismatch, err_cnt, cmp_cnt, busy, halted
    );
endinterface

// File: rtl/jk_ff_checker.sv
// JK flip-flop checker: predicts Q from the JK command stream
// and counts mismatches against the observed Q/Qn pair.
module jk_ff_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input logic            clk,
    input logic            rst,
    jk_ff_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CHECK,
        HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic             r_exp_q;
    logic             w_exp_nxt;
    logic             w_pred;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_cmp_cnt;
    logic             w_cmp_do;
    logic             w_fail;

    // A comparison happens only while actively checking and
    // the observed flop is not itself being reset.
    assign w_cmp_do = (r_state == CHECK) && bus.chk_en
                   && !bus.dut_rst;
    assign w_fail   = w_cmp_do
                   && ((bus.q != r_exp_q) || (bus.qn == bus.q));

    // JK prediction of the next Q from the applied command.
    always_comb begin
        w_pred = r_exp_q;
        unique case (bus.state)
            2'b00: w_pred = r_exp_q;
            2'b01: w_pred = 1'b1;
            2'b10: w_pred = 1'b0;
            2'b11: w_pred = ~r_exp_q;
        endcase
    end

    // Next state and next predicted Q.
    always_comb begin
        w_next    = r_state;
        w_exp_nxt = r_exp_q;
        if (!bus.chk_en) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: w_next = SYNC;
                SYNC: begin
                    w_next    = CHECK;
                    w_exp_nxt = bus.q;
                end
                CHECK: begin
                    if (w_fail && STOP_ON_ERR)
                        w_next = HALT;
                    w_exp_nxt = bus.dut_rst ? 1'b0 : w_pred;
                end
                HALT: w_next = HALT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Prediction, mismatch pulse and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exp_q    <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
            r_cmp_cnt  <= '0;
        end else begin
            r_exp_q    <= w_exp_nxt;
            r_mismatch <= w_fail;
            if (w_cmp_do && (r_cmp_cnt != CNT_MAX))
                r_cmp_cnt <= r_cmp_cnt + 1'b1;
            if (w_fail && (r_err_cnt != CNT_MAX))
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.exp_q    = r_exp_q;
    assign bus.mismatch = r_mismatch;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.cmp_cnt  = r_cmp_cnt;
    assign bus.busy     = (r_state == SYNC) || (r_state == CHECK);
    assign bus.halted   = (r_state == HALT);
endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed scoreboard bench for jk_ff_checker: three instances
// (free-running, stop-on-error, 3-bit saturating counters).
module tb_jk_ff_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       en   [3];
    logic       drst [3];
    logic [1:0] st   [3];
    logic       qv   [3];
    logic       qnv  [3];

    logic       o_eq  [3];
    logic       o_mis [3];
    logic [7:0] o_err [3];
    logic [7:0] o_cmp [3];
    logic       o_busy[3];
    logic       o_halt[3];

    jk_ff_checker_if #(.CNT_W(8)) if0 ();
    jk_ff_checker_if #(.CNT_W(8)) if1 ();
    jk_ff_checker_if #(.CNT_W(3)) if2 ();

    assign if0.chk_en  = en[0];
    assign if0.dut_rst = drst[0];
    assign if0.state   = st[0];
    assign if0.q       = qv[0];
    assign if0.qn      = qnv[0];
    assign if1.chk_en  = en[1];
    assign if1.dut_rst = drst[1];
    assign if1.state   = st[1];
    assign if1.q       = qv[1];
    assign if1.qn      = qnv[1];
    assign if2.chk_en  = en[2];
    assign if2.dut_rst = drst[2];
    assign if2.state   = st[2];
    assign if2.q       = qv[2];
    assign if2.qn      = qnv[2];

    assign o_eq[0]   = if0.exp_q;
    assign o_mis[0]  = if0.mismatch;
    assign o_err[0]  = if0.err_cnt;
    assign o_cmp[0]  = if0.cmp_cnt;
    assign o_busy[0] = if0.busy;
    assign o_halt[0] = if0.halted;
    assign o_eq[1]   = if1.exp_q;
    assign o_mis[1]  = if1.mismatch;
    assign o_err[1]  = if1.err_cnt;
    assign o_cmp[1]  = if1.cmp_cnt;
    assign o_busy[1] = if1.busy;
    assign o_halt[1] = if1.halted;
    assign o_eq[2]   = if2.exp_q;
    assign o_mis[2]  = if2.mismatch;
    assign o_err[2]  = {5'b0, if2.err_cnt};
    assign o_cmp[2]  = {5'b0, if2.cmp_cnt};
    assign o_busy[2] = if2.busy;
    assign o_halt[2] = if2.halted;

    jk_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    jk_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    jk_ff_checker #(.CNT_W(3), .STOP_ON_ERR(1'b0)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        int         idx;
        string      tag;
        logic       eq;
        logic       mis;
        logic [7:0] err;
        logic [7:0] cmp;
        logic       busy;
        logic       halt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] obs,
                       input logic [7:0] ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h",
                   tag, fld, obs, ex);
        end
    endtask

    task automatic drv(input int i, input logic e,
                       input logic d, input logic [1:0] s,
                       input logic q, input logic qn);
        en[i]   = e;
        drst[i] = d;
        st[i]   = s;
        qv[i]   = q;
        qnv[i]  = qn;
    endtask

    task automatic expect_out(input int i, input string tag,
                              input logic eq, input logic mis,
                              input int err, input int cmp,
                              input logic b, input logic h);
        exp_t x;
        x.idx  = i;
        x.tag  = tag;
        x.eq   = eq;
        x.mis  = mis;
        x.err  = 8'(err);
        x.cmp  = 8'(cmp);
        x.busy = b;
        x.halt = h;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, "exp_q", {7'b0, o_eq[x.idx]}, {7'b0, x.eq});
            chk(x.tag, "mismatch", {7'b0, o_mis[x.idx]},
                {7'b0, x.mis});
            chk(x.tag, "err_cnt", o_err[x.idx], x.err);
            chk(x.tag, "cmp_cnt", o_cmp[x.idx], x.cmp);
            chk(x.tag, "busy", {7'b0, o_busy[x.idx]},
                {7'b0, x.busy});
            chk(x.tag, "halted", {7'b0, o_halt[x.idx]},
                {7'b0, x.halt});
        end
    endtask

    task automatic step(input int i, input string tag,
                        input logic e, input logic d,
                        input logic [1:0] s, input logic q,
                        input logic qn, input logic eq,
                        input logic mis, input int err,
                        input int cmp, input logic b,
                        input logic h);
        drv(i, e, d, s, q, qn);
        expect_out(i, tag, eq, mis, err, cmp, b, h);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) drv(i, 1, 0, 2'b00, 0, 1);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++)
                expect_out(i, "rst", 0, 0, 0, 0, 0, 0);
            tick();
        end

        rst = 1'b1;
        drv(1, 0, 0, 2'b00, 0, 1);
        drv(2, 0, 0, 2'b00, 0, 1);
        expect_out(1, "idle1", 0, 0, 0, 0, 0, 0);
        step(0, "sync0", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
        step(0, "load0", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);

        step(0, "seq01", 1, 0, 2'b01, 0, 1, 1, 0, 0, 1, 1, 0);
        step(0, "seq11a", 1, 0, 2'b11, 1, 0, 0, 0, 0, 2, 1, 0);
        step(0, "seq11b", 1, 0, 2'b11, 0, 1, 1, 0, 0, 3, 1, 0);
        step(0, "seq00", 1, 0, 2'b00, 1, 0, 1, 0, 0, 4, 1, 0);
        step(0, "seq10", 1, 0, 2'b10, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, "seq11c", 1, 0, 2'b11, 0, 1, 1, 0, 0, 6, 1, 0);

        step(0, "drst", 1, 1, 2'b11, 1, 0, 0, 0, 0, 6, 1, 0);
        step(0, "drst_after", 1, 0, 2'b00, 0, 1, 0, 0, 0, 7, 1, 0);

        step(0, "cset", 1, 0, 2'b01, 0, 1, 1, 0, 0, 8, 1, 0);
        step(0, "qn_eq_q", 1, 0, 2'b00, 1, 1, 1, 1, 1, 9, 1, 0);
        step(0, "qn_ok", 1, 0, 2'b00, 1, 0, 1, 0, 1, 10, 1, 0);

        step(0, "f_rst", 1, 0, 2'b10, 1, 0, 0, 0, 1, 11, 1, 0);
        step(0, "f_set", 1, 0, 2'b01, 0, 1, 1, 0, 1, 12, 1, 0);
        step(0, "stuck0", 1, 0, 2'b01, 0, 1, 1, 1, 2, 13, 1, 0);
        step(0, "stuck_nx", 1, 0, 2'b01, 1, 0, 1, 0, 2, 14, 1, 0);

        step(0, "idle0", 0, 0, 2'b00, 1, 0, 1, 0, 2, 14, 0, 0);
        step(0, "resync0", 1, 0, 2'b00, 1, 0, 1, 0, 2, 14, 1, 0);
        step(0, "rechk0", 1, 0, 2'b00, 1, 0, 1, 0, 2, 14, 1, 0);

        step(1, "sync1", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
        step(1, "load1", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
        step(1, "set1", 1, 0, 2'b01, 0, 1, 1, 0, 0, 1, 1, 0);
        step(1, "stop1", 1, 0, 2'b01, 0, 1, 1, 1, 1, 2, 0, 1);
        for (int k = 0; k < 5; k++)
            step(1, "frozen1", 1, 0, 2'b11, 1, 1,
                 1, 0, 1, 2, 0, 1);
        step(1, "unhalt1", 0, 0, 2'b00, 0, 1, 1, 0, 1, 2, 0, 0);
        step(1, "resync1", 1, 0, 2'b00, 0, 1, 1, 0, 1, 2, 1, 0);
        step(1, "reload1", 1, 0, 2'b00, 0, 1, 0, 0, 1, 2, 1, 0);
        step(1, "set1b", 1, 0, 2'b01, 0, 1, 1, 0, 1, 3, 1, 0);
        step(1, "stop1b", 1, 0, 2'b01, 0, 1, 1, 1, 2, 4, 0, 1);

        step(2, "sync2", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
        step(2, "load2", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++)
            step(2, "sat", 1, 0, 2'b00, 1, 0, 0, 1,
                 (k > 7) ? 7 : k, (k > 7) ? 7 : k, 1, 0);
        step(2, "sat_hold", 1, 0, 2'b00, 1, 0, 0, 1, 7, 7, 1, 0);
        step(2, "sat_idle", 0, 0, 2'b00, 1, 0, 0, 0, 7, 7, 0, 0);
        step(2, "sat_sync", 1, 0, 2'b00, 1, 0, 0, 0, 7, 7, 1, 0);

        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_out(i, "rst_mid", 0, 0, 0, 0, 0, 0);
        tick();

        rst = 1'b1;
        drv(1, 0, 0, 2'b00, 0, 1);
        drv(2, 0, 0, 2'b00, 0, 1);
        expect_out(1, "post_rst1", 0, 0, 0, 0, 0, 0);
        step(0, "post_rst0", 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
